// File: rtl/histo_pkg.sv
// Shared definitions for the histogram serial ingest link: frame FSM states,
// timing constants and mask statistics helpers used by transmitter and receiver.
package histo_pkg;

    localparam int DEFAULT_MAX_SEQ_SIZE = 16;
    localparam int LEAD_CYCLES          = 1;
    localparam int FN_W                 = 64;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        LEAD,
        SEND,
        GAP
    } fsm_t;

    function automatic int unsigned popcount(input logic [FN_W-1:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < FN_W; i++) begin
            if (m[i]) n++;
        end
        return n;
    endfunction

    // Counts 0->1 transitions, treating the bit below slot 0 as 0.
    function automatic int unsigned run_count(input logic [FN_W-1:0] m);
        int unsigned n;
        logic        prev;
        n    = 0;
        prev = 1'b0;
        for (int i = 0; i < FN_W; i++) begin
            if (m[i] && !prev) n++;
            prev = m[i];
        end
        return n;
    endfunction

endpackage

// File: rtl/histo_mask_stats.sv
// Combinational statistics of a frame mask: number of valid slots and whether
// the valid slots form more than one contiguous run.
module histo_mask_stats
    import histo_pkg::*;
#(
    parameter int MAX_SEQ_SIZE = DEFAULT_MAX_SEQ_SIZE
) (
    input  logic [MAX_SEQ_SIZE-1:0]       mask,
    output logic [$clog2(MAX_SEQ_SIZE):0] len,
    output logic                          noncontig
);

    localparam int LEN_W = $clog2(MAX_SEQ_SIZE) + 1;

    always_comb begin
        len       = LEN_W'(popcount(FN_W'(mask)));
        noncontig = (run_count(FN_W'(mask)) > 32'd1);
    end

endmodule

// File: rtl/histo_seq_tx.sv
// Frame transmitter for the histogram serial ingest link: accepts one
// descriptor, then emits hist_int, a lead gap and MAX_SEQ_SIZE LSB-first slots.
module histo_seq_tx
    import histo_pkg::*;
#(
    parameter int MAX_SEQ_SIZE = DEFAULT_MAX_SEQ_SIZE,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [MAX_SEQ_SIZE-1:0]       req_mask,
    input  logic [MAX_SEQ_SIZE-1:0]       req_data,
    output logic                          hist_int,
    output logic                          data_valid,
    output logic                          data_in,
    output logic                          busy,
    output logic [$clog2(MAX_SEQ_SIZE):0] tx_len,
    output logic                          err_noncontig,
    output logic [CNT_W-1:0]              frame_cnt
);

    localparam int LEN_W = $clog2(MAX_SEQ_SIZE) + 1;
    localparam int CW    = $clog2(MAX_SEQ_SIZE + GAP_CYCLES + LEAD_CYCLES + 1);

    fsm_t                    state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [MAX_SEQ_SIZE-1:0] mask_reg, mask_next;
    logic [MAX_SEQ_SIZE-1:0] data_reg, data_next;
    logic                    hist_int_reg, hist_int_next;
    logic                    data_valid_reg, data_valid_next;
    logic                    data_in_reg, data_in_next;
    logic [LEN_W-1:0]        tx_len_reg;
    logic                    err_reg;
    logic [CNT_W-1:0]        frame_cnt_reg;
    logic                    accept;
    logic                    frame_done;
    logic [LEN_W-1:0]        stats_len;
    logic                    stats_noncontig;

    histo_mask_stats #(
        .MAX_SEQ_SIZE(MAX_SEQ_SIZE)
    ) u_stats (
        .mask      (req_mask),
        .len       (stats_len),
        .noncontig (stats_noncontig)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mask_next  = mask_reg;
        data_next  = data_reg;
        accept     = 1'b0;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    mask_next  = req_mask;
                    data_next  = req_data;
                    state_next = PULSE;
                end
            end
            PULSE: begin
                state_next = LEAD;
                cnt_next   = '0;
            end
            LEAD: begin
                if (cnt_reg == CW'(LEAD_CYCLES - 1)) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            SEND: begin
                mask_next = mask_reg >> 1;
                data_next = data_reg >> 1;
                if (cnt_reg == CW'(MAX_SEQ_SIZE - 1)) begin
                    state_next = GAP;
                    cnt_next   = '0;
                    frame_done = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            GAP: begin
                if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Serial outputs are computed one cycle early so they leave on flops.
        hist_int_next   = (state_next == PULSE);
        data_valid_next = (state_next == SEND) && mask_next[0];
        data_in_next    = data_valid_next && data_next[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            mask_reg       <= '0;
            data_reg       <= '0;
            hist_int_reg   <= 1'b0;
            data_valid_reg <= 1'b0;
            data_in_reg    <= 1'b0;
            tx_len_reg     <= '0;
            err_reg        <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            mask_reg       <= mask_next;
            data_reg       <= data_next;
            hist_int_reg   <= hist_int_next;
            data_valid_reg <= data_valid_next;
            data_in_reg    <= data_in_next;
            if (accept) begin
                tx_len_reg <= stats_len;
                err_reg    <= stats_noncontig;
            end
            if (frame_done) begin
                frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign hist_int      = hist_int_reg;
    assign data_valid    = data_valid_reg;
    assign data_in       = data_in_reg;
    assign tx_len        = tx_len_reg;
    assign err_noncontig = err_reg;
    assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_histo_seq_tx.sv
// Self-checking bench for histo_seq_tx: a per-cycle expectation timeline is
// built from each accepted descriptor and compared against the DUT every cycle.
module tb_histo_seq_tx;

    localparam int MS     = 16;
    localparam int GAPC   = 1;
    localparam int CNTW   = 16;
    localparam int PERIOD = MS + GAPC + 3;
    localparam int NC     = 8192;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [MS-1:0] req_mask = '0;
    logic [MS-1:0] req_data = '0;
    logic          req_ready;
    logic          hist_int;
    logic          data_valid;
    logic          data_in;
    logic          busy;
    logic [4:0]    tx_len;
    logic          err_noncontig;
    logic [15:0]   frame_cnt;

    histo_seq_tx #(
        .MAX_SEQ_SIZE(MS),
        .GAP_CYCLES  (GAPC),
        .CNT_W       (CNTW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_mask     (req_mask),
        .req_data     (req_data),
        .hist_int     (hist_int),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .busy         (busy),
        .tx_len       (tx_len),
        .err_noncontig(err_noncontig),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected value of every output for every cycle index.
    int exp_hist[NC];
    int exp_dv[NC];
    int exp_din[NC];
    int exp_rdy[NC];
    int exp_len[NC];
    int exp_err[NC];
    int exp_fc[NC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int pop(input logic [MS-1:0] m);
        logic [MS-1:0] v;
        int n;
        v = m;
        n = 0;
        while (v != '0) begin
            v = v & (v - 1'b1);
            n++;
        end
        return n;
    endfunction

    // Runs = number of value changes along the padded mask, divided by two.
    function automatic int runs(input logic [MS-1:0] m);
        logic [MS+1:0] p;
        int edges;
        p = {1'b0, m, 1'b0};
        edges = 0;
        for (int k = 0; k <= MS; k++) begin
            if (p[k] != p[k+1]) edges++;
        end
        return edges / 2;
    endfunction

    task automatic model_accept(input int c, input logic [MS-1:0] m, input logic [MS-1:0] d);
        int len;
        int err;
        len = pop(m);
        err = (runs(m) > 1) ? 1 : 0;
        for (int i = c + 1; i < c + PERIOD; i++) exp_rdy[i] = 0;
        exp_hist[c+1] = 1;
        for (int k = 0; k < MS; k++) begin
            exp_dv[c+3+k]  = int'(m[k]);
            exp_din[c+3+k] = int'(m[k] & d[k]);
        end
        for (int i = c + 1; i < NC; i++) begin
            exp_len[i] = len;
            exp_err[i] = err;
        end
        for (int i = c + PERIOD - 1; i < NC; i++) exp_fc[i] = (exp_fc[i] + 1) % 65536;
        $display("accept cyc=%0d mask=%04h data=%04h len=%0d noncontig=%0d", c, m, d, len, err);
    endtask

    task automatic model_reset(input int c);
        for (int i = c; i < NC; i++) begin
            exp_hist[i] = 0; exp_dv[i] = 0; exp_din[i] = 0; exp_rdy[i] = 1;
            exp_len[i]  = 0; exp_err[i] = 0; exp_fc[i]  = 0;
        end
    endtask

    task automatic step(input bit v, input logic [MS-1:0] m, input logic [MS-1:0] d, output bit acc);
        @(posedge clk);
        #1;
        req_valid = v;
        req_mask  = m;
        req_data  = d;
        acc = 1'b0;
        if (v && exp_rdy[cyc] == 1) begin
            model_accept(cyc, m, d);
            acc = 1'b1;
        end
    endtask

    task automatic send(input logic [MS-1:0] m, input logic [MS-1:0] d, output int acc_c);
        bit a;
        int t;
        t = 0;
        a = 1'b0;
        acc_c = -1;
        while (!a && t < 100) begin
            step(1'b1, m, d, a);
            t++;
        end
        if (a) acc_c = cyc;
        else begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout cyc=%0d got=no_accept expected=accept", cyc);
        end
    endtask

    task automatic idle(input int n, input bit noisy);
        bit a;
        for (int i = 0; i < n; i++) begin
            step(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom), 16'($urandom), a);
        end
    endtask

    task automatic idle_until(input int c);
        bit a;
        while (cyc < c) step(1'b0, 16'($urandom), 16'($urandom), a);
    endtask

    always @(negedge clk) begin
        if (rst_n && cyc < NC) begin
            chk("hist_int",      32'(hist_int),      32'(exp_hist[cyc]));
            chk("data_valid",    32'(data_valid),    32'(exp_dv[cyc]));
            chk("data_in",       32'(data_in),       32'(exp_din[cyc]));
            chk("req_ready",     32'(req_ready),     32'(exp_rdy[cyc]));
            chk("busy",          32'(busy),          32'(1 - exp_rdy[cyc]));
            chk("tx_len",        32'(tx_len),        32'(exp_len[cyc]));
            chk("err_noncontig", 32'(err_noncontig), 32'(exp_err[cyc]));
            chk("frame_cnt",     32'(frame_cnt),     32'(exp_fc[cyc]));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc[5];
        int cnt;
        logic [MS-1:0] five_m[5];
        logic [MS-1:0] rm;

        model_reset(0);

        // Power-on reset values.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready",  32'(req_ready),  32'd1);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_hist_int",   32'(hist_int),   32'd0);
        chk("rst_data_valid", 32'(data_valid), 32'd0);
        chk("rst_tx_len",     32'(tx_len),     32'd0);
        chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset during slot 7 aborts the frame asynchronously.
        send(16'hFFFF, 16'hA5A5, t);
        idle_until(t + 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_data_valid", 32'(data_valid), 32'd0);
        chk("arst_data_in",    32'(data_in),    32'd0);
        chk("arst_busy",       32'(busy),       32'd0);
        chk("arst_req_ready",  32'(req_ready),  32'd1);
        chk("arst_tx_len",     32'(tx_len),     32'd0);
        model_reset(cyc);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("arst_ready_rel", 32'(req_ready), 32'd1);

        // Single frame 0x000C / 0x0008.
        send(16'h000C, 16'h0008, t);
        idle_until(t + PERIOD + 1);
        chk("pin_hist_t1", 32'(exp_hist[t+1]), 32'd1);
        chk("pin_dv_t5",   32'(exp_dv[t+5]),   32'd1);
        chk("pin_dv_t6",   32'(exp_dv[t+6]),   32'd1);
        chk("pin_din_t5",  32'(exp_din[t+5]),  32'd0);
        chk("pin_din_t6",  32'(exp_din[t+6]),  32'd1);
        cnt = 0;
        for (int i = t + 3; i <= t + 18; i++) cnt += exp_dv[i];
        chk("pin_dv_count", 32'(cnt), 32'd2);
        chk("a_tx_len",     32'(tx_len),        32'd2);
        chk("a_noncontig",  32'(err_noncontig), 32'd0);
        chk("a_frame_cnt",  32'(frame_cnt),     32'd1);

        // Five descriptors with valid held high.
        five_m = '{16'h000C, 16'h0070, 16'h0010, 16'h00FF, 16'h00C0};
        for (int i = 0; i < 5; i++) send(five_m[i], 16'($urandom), acc[i]);
        for (int i = 1; i < 5; i++) chk("b2b_period", 32'(acc[i] - acc[i-1]), 32'd20);
        idle_until(acc[4] + PERIOD + 1);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'd6);
        chk("b2b_tx_len",    32'(tx_len),    32'd2);

        // Non-contiguous mask.
        send(16'h0505, 16'h0104, t);
        idle(2, 1'b0);
        chk("nc_err",    32'(err_noncontig), 32'd1);
        chk("nc_tx_len", 32'(tx_len),        32'd4);
        idle_until(t + PERIOD);

        // Full and empty masks.
        send(16'hFFFF, 16'h3C5A, t);
        idle(2, 1'b0);
        chk("full_tx_len", 32'(tx_len), 32'd16);
        cnt = 0;
        for (int i = t + 3; i <= t + 18; i++) cnt += exp_dv[i];
        chk("pin_full_dv", 32'(cnt), 32'd16);
        idle_until(t + PERIOD);
        send(16'h0000, 16'hFFFF, t);
        idle(2, 1'b0);
        chk("zero_tx_len", 32'(tx_len),        32'd0);
        chk("zero_err",    32'(err_noncontig), 32'd0);
        idle_until(t + PERIOD);

        // Valid toggled while busy; held request lands on the first IDLE cycle.
        send(16'h00F0, 16'h0030, t);
        idle(8, 1'b1);
        send(16'h0003, 16'h0001, acc[0]);
        chk("toggle_accept_delay", 32'(acc[0] - t), 32'd20);

        // Randomised descriptors, with noisy idle gaps between them.
        for (int n = 0; n < 120 && cyc + 3 * PERIOD < NC; n++) begin
            case ($urandom_range(0, 4))
                0: rm = 16'h0000;
                1: rm = 16'hFFFF;
                2: rm = 16'((32'hFFFF >> $urandom_range(0, 15)) << $urandom_range(0, 8));
                default: rm = 16'($urandom);
            endcase
            send(rm, 16'($urandom), t);
            idle($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        idle(PERIOD + 5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/histo_seq_tx.md
Name: histo_seq_tx

Overview:
Frame transmitter for the histogram serial ingest interface (hist_int / data_valid / data_in), i.e. the source side of that link. It accepts one frame descriptor at a time over a valid/ready handshake and serialises it LSB-first. Each frame is a one-cycle hist_int pulse, a fixed lead gap, then exactly MAX_SEQ_SIZE data slots. It replaces bench-side hand-sequencing and feeds the histogram block in system-level builds.

Parameters:
MAX_SEQ_SIZE, 16, slots per frame; width of mask/data descriptors
GAP_CYCLES, 1, idle cycles after the last slot before req_ready can reassert (min 1)
CNT_W, 16, width of frame counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  descriptor valid
req_ready  out  1  block can accept a descriptor
req_mask  in  MAX_SEQ_SIZE  per-slot data_valid pattern, bit k = slot k
req_data  in  MAX_SEQ_SIZE  per-slot data_in pattern, bit k = slot k
hist_int  out  1  frame-start pulse to receiver
data_valid  out  1  slot valid
data_in  out  1  slot data
busy  out  1  high from accept through end of GAP
tx_len  out  $clog2(MAX_SEQ_SIZE)+1  popcount of req_mask, latched at accept
err_noncontig  out  1  latched at accept: mask has more than one run of 1s
frame_cnt  out  CNT_W  frames fully transmitted, wraps at 2^CNT_W

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready=1; hist_int=data_valid=data_in=0; busy=0; tx_len=0; err_noncontig=0; frame_cnt=0; shift registers cleared. Reset mid-frame aborts immediately; the partial frame is not resumed and frame_cnt is not incremented.
- States: IDLE, PULSE, LEAD, SEND, GAP.
- IDLE: req_ready=1. On req_valid&&req_ready: capture req_mask/req_data into shift regs; latch tx_len and err_noncontig; go to PULSE. req_ready is combinationally (state==IDLE).
- PULSE (1 cycle): hist_int=1, data_valid=0, go to LEAD.
- LEAD (1 cycle): all outputs low. Slot 0 is therefore driven exactly 2 cycles after the hist_int cycle.
- SEND (MAX_SEQ_SIZE cycles, slot counter 0..MAX_SEQ_SIZE-1): data_valid=mask[k], data_in=data[k] & mask[k] (data_in is forced 0 when data_valid=0); shift right each cycle. On k==MAX_SEQ_SIZE-1: go to GAP and increment frame_cnt on the same edge.
- GAP (GAP_CYCLES cycles): all serial outputs low; then IDLE. Back-to-back descriptors: minimum frame period = MAX_SEQ_SIZE+GAP_CYCLES+3 cycles.
- All serial outputs are registered; no combinational path from req_* to hist_int/data_valid/data_in.
- Accept-to-hist_int latency: 1 cycle (hist_int high the cycle after the handshake edge).
- req_mask=0: the frame is still sent (pulse + MAX_SEQ_SIZE empty slots); tx_len=0, err_noncontig=0.
- req_mask all ones: tx_len=MAX_SEQ_SIZE; the width must hold MAX_SEQ_SIZE without overflow.
- err_noncontig: informational only, does not block transmission; holds until the next accept.
- Descriptor inputs are ignored when req_ready=0; req_valid held during busy is not consumed until IDLE.
- tx_len, err_noncontig and frame_cnt are registered and stable outside their update edge.

Decomposition:
- Package histo_pkg: fsm enum (IDLE, PULSE, LEAD, SEND, GAP), LEAD_CYCLES=1 constant, MAX_SEQ_SIZE default, function popcount and function run_count (number of 0->1 transitions in a mask), shared with the receiver and the bench.
- One natural sub-module: histo_mask_stats, combinational popcount plus run-count on req_mask, registered by the parent at accept.

Test Plan:
- Mask 16'h000C, data 16'h0008 -> hist_int at T+1; slots at T+3..T+18; data_valid high only in cycles T+5 and T+6; data_in high only in T+6; tx_len=2; err_noncontig=0; frame_cnt=1.
- Five descriptors held back-to-back (0x000C, 0x0070, 0x0010, 0x00FF, 0x00C0) -> five frames, each period 20 cycles with GAP_CYCLES=1; tx_len sequence 2,3,1,8,2; frame_cnt=5; receiver histogram bins 1,2,3,8 read back 1,2,1,1.
- Mask 16'h0505 -> err_noncontig=1, tx_len=4; the frame is still transmitted bit-exact.
- Mask 16'hFFFF -> data_valid high for all 16 slots; tx_len=16. Mask 0 -> hist_int pulses, data_valid never high.
- rst_n low during slot 7 -> all outputs 0 asynchronously; after release req_ready=1 and frame_cnt unchanged (0).
- req_valid toggled during SEND -> not accepted; req_ready=0 throughout busy; next accept occurs in the first IDLE cycle.
